// File: rtl/alu_issue_seq.sv
// Issue/write-back sequencer in front of a registered 32-bit ALU.
// Owns an 8 x W register file and runs one instruction at a time.
module alu_issue_seq #(
  parameter int NREG = 8,
  parameter int W    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [12:0]  instr,
  input  logic [W-1:0] imm,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_f,
  input  logic [W-1:0] alu_y,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [W-1:0] result,
  output logic         result_err,
  input  logic [2:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);

  localparam int IW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_SUB   = 4'd2,
    OP_EQ    = 4'd3,
    OP_GT    = 4'd4,
    OP_LOADI = 4'd8
  } op_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q;
  logic [IW-1:0]  rd_q, rs1_q, rs2_q;
  logic [W-1:0]   regs [NREG];
  logic [W-1:0]   result_q;
  logic           err_q;

  // Instruction field decode
  logic [3:0]     in_op;
  logic [IW-1:0]  in_rd, in_rs1, in_rs2;
  logic           accept, is_alu, is_loadi;

  assign in_op    = instr[3:0];
  assign in_rd    = instr[4 +: IW];
  assign in_rs1   = instr[7 +: IW];
  assign in_rs2   = instr[10 +: IW];
  assign is_alu   = (in_op <= OP_GT);
  assign is_loadi = (in_op == OP_LOADI);

  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;

  // Write-back and result-load controls
  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [W-1:0]   wr_data;
  logic           res_en;
  logic [W-1:0]   res_data;
  logic           res_err;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    wr_en    = 1'b0;
    wr_idx   = rd_q;
    wr_data  = alu_y;
    res_en   = 1'b0;
    res_data = alu_y;
    res_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_alu) begin
            state_d = ISSUE;
          end else begin
            state_d = RESP;
            res_en  = 1'b1;
            if (is_loadi) begin
              wr_en    = 1'b1;
              wr_idx   = in_rd;
              wr_data  = imm;
              res_data = imm;
            end else begin
              res_data = '0;
              res_err  = 1'b1;
            end
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // ALU result registered at the ISSUE->WAIT edge is valid now
        state_d = RESP;
        wr_en   = 1'b1;
        res_en  = 1'b1;
      end
      RESP: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (accept) begin
      op_q  <= in_op;
      rd_q  <= in_rd;
      rs1_q <= in_rs1;
      rs2_q <= in_rs2;
    end
  end

  // NOTE: the register file is architecturally visible and must read 0 after reset, so it is reset
  // explicitly; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (res_en) begin
      result_q <= res_data;
      err_q    <= res_err;
    end
  end

  // Operands come from latched fields so they stay stable until the next accept
  assign alu_a        = regs[rs1_q];
  assign alu_b        = regs[rs2_q];
  assign alu_f        = op_q;
  assign result_valid = (state_q == RESP);
  assign result       = result_q;
  assign result_err   = err_q;
  assign dbg_data     = regs[dbg_sel];

endmodule
